// File: rtl/dsp_mac_sequencer_if.sv
// rtl/dsp_mac_sequencer_if.sv - operand, result and DSP slice signals of the MAC sequencer
interface dsp_mac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cep;
  logic        dsp_rstp;
  logic [47:0] dsp_p;
  logic        r_valid;
  logic        r_ready;
  logic [47:0] r_data;

  modport slave (
    input  s_valid, s_a, s_b, r_ready, dsp_p,
    output s_ready, r_valid, r_data, dsp_a, dsp_b, dsp_opmode, dsp_cep, dsp_rstp
  );

  modport master (
    output s_valid, s_a, s_b, r_ready, dsp_p,
    input  s_ready, r_valid, r_data, dsp_a, dsp_b, dsp_opmode, dsp_cep, dsp_rstp
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - drives a 48-bit DSP slice to accumulate a LEN-beat dot product
module dsp_mac_sequencer #(
  parameter int LEN        = 8,
  parameter int MUL_LAT    = 2,
  parameter int OPMODE_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  dsp_mac_sequencer_if.slave mac
);
  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int OP_TAP = MUL_LAT - OPMODE_REG;
  localparam int F_W    = (OP_TAP > 0) ? OP_TAP : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MUL_LAT:0] v_pipe;
  logic [F_W-1:0]   f_pipe;
  logic             accept;
  logic             first_now;
  logic [MUL_LAT:0] v_tap;
  logic [F_W:0]     f_tap;

  // Tap d of the delay lines describes the beat accepted d edges earlier.
  assign accept    = mac.s_valid & mac.s_ready;
  assign first_now = accept & (cnt == '0);
  assign v_tap     = {v_pipe[MUL_LAT-1:0], accept};
  assign f_tap     = {f_pipe, first_now};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      v_pipe         <= '0;
      f_pipe         <= '0;
      mac.s_ready    <= 1'b0;
      mac.dsp_a      <= '0;
      mac.dsp_b      <= '0;
      mac.dsp_opmode <= '0;
      mac.dsp_cep    <= 1'b0;
      mac.dsp_rstp   <= 1'b0;
      mac.r_valid    <= 1'b0;
      mac.r_data     <= '0;
    end else begin
      v_pipe         <= v_tap;
      f_pipe         <= f_tap[F_W-1:0];
      mac.dsp_rstp   <= 1'b0;
      mac.dsp_cep    <= v_tap[MUL_LAT];
      mac.dsp_opmode <= v_tap[OP_TAP] ? (f_tap[OP_TAP] ? 8'h01 : 8'h09) : 8'h00;

      if (abort) begin
        state          <= STREAM;
        cnt            <= '0;
        v_pipe         <= '0;
        f_pipe         <= '0;
        mac.s_ready    <= 1'b1;
        mac.r_valid    <= 1'b0;
        mac.dsp_rstp   <= 1'b1;
        mac.dsp_cep    <= 1'b0;
        mac.dsp_opmode <= 8'h00;
      end else begin
        case (state)
          IDLE: begin
            state       <= STREAM;
            mac.s_ready <= 1'b1;
          end
          STREAM: begin
            if (accept) begin
              mac.dsp_a <= mac.s_a;
              mac.dsp_b <= mac.s_b;
              if (cnt == LAST) begin
                cnt         <= '0;
                mac.s_ready <= 1'b0;
                state       <= DRAIN;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          // Once every slot has left the delay line the slice P holds the final sum.
          DRAIN: begin
            if (v_pipe == '0) begin
              mac.r_data  <= mac.dsp_p;
              mac.r_valid <= 1'b1;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (mac.r_ready) begin
              mac.r_valid <= 1'b0;
              mac.s_ready <= 1'b1;
              state       <= STREAM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - directed bench with DSP slice model and timing/result scoreboards
module tb_dsp_mac_sequencer;
  localparam int LEN        = 4;
  localparam int MUL_LAT    = 2;
  localparam int OPMODE_REG = 1;

  typedef struct {
    int         at;
    logic [7:0] val;
  } op_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  int          cep_q[$];
  op_exp_t     op_q[$];
  int          rise_q[$];
  logic [47:0] res_q[$];
  int          beat_idx = 0;
  logic [47:0] exp_sum  = '0;
  logic        r_valid_q = 1'b0;
  op_exp_t     oe;

  dsp_mac_sequencer_if mac();

  dsp_mac_sequencer #(
    .LEN(LEN),
    .MUL_LAT(MUL_LAT),
    .OPMODE_REG(OPMODE_REG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .mac(mac)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: A1/B1 register, M register, optional OPMODE register, P register.
  logic [17:0] a1 = '0;
  logic [17:0] b1 = '0;
  logic [47:0] m  = '0;
  logic [47:0] p  = '0;
  logic [7:0]  opm_r = '0;
  wire  [7:0]  opm_eff = (OPMODE_REG != 0) ? opm_r : mac.dsp_opmode;
  assign mac.dsp_p = p;

  always @(posedge clk) begin
    a1    <= mac.dsp_a;
    b1    <= mac.dsp_b;
    m     <= 48'(a1) * 48'(b1);
    opm_r <= mac.dsp_opmode;
    if (mac.dsp_rstp) p <= '0;
    else if (mac.dsp_cep) p <= (opm_eff[0] ? m : 48'd0) + (opm_eff[3] ? p : 48'd0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      r_valid_q = 1'b0;
    end else begin
      if (mac.dsp_cep) begin
        if (cep_q.size() == 0) check("cep_unexpected", mac.dsp_cep, 0);
        else check("cep_edge", cyc, cep_q.pop_front());
      end
      if (mac.dsp_opmode != 8'h00) begin
        if (op_q.size() == 0) check("opmode_unexpected", mac.dsp_opmode, 0);
        else begin
          oe = op_q.pop_front();
          check("opmode_edge", cyc, oe.at);
          check("opmode_val", mac.dsp_opmode, oe.val);
        end
      end
      if (mac.r_valid && !r_valid_q) begin
        if (rise_q.size() == 0) check("rvalid_unexpected", mac.r_valid, 0);
        else check("rvalid_rise", cyc, rise_q.pop_front());
      end
      r_valid_q = mac.r_valid;
    end
  end

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    int acc;
    mac.s_valid = 1'b1;
    mac.s_a     = a;
    mac.s_b     = b;
    while (!mac.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mac.s_ready) begin
      check("send_timeout", mac.s_ready, 1);
      mac.s_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    cep_q.push_back(acc + MUL_LAT);
    op_q.push_back('{acc + MUL_LAT - OPMODE_REG, (beat_idx == 0) ? 8'h01 : 8'h09});
    exp_sum += 48'(a) * 48'(b);
    beat_idx++;
    if (beat_idx == LEN) begin
      res_q.push_back(exp_sum);
      rise_q.push_back(acc + MUL_LAT + 2);
      beat_idx = 0;
      exp_sum  = '0;
    end
    @(negedge clk);
    mac.s_valid = 1'b0;
  endtask

  task automatic get_result(input int hold);
    int n = 0;
    logic [47:0] exp;
    while (!mac.r_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mac.r_valid) begin
      check("rvalid_timeout", mac.r_valid, 1);
      return;
    end
    if (res_q.size() == 0) begin
      check("result_unscheduled", mac.r_valid, 0);
      return;
    end
    exp = res_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("r_data_hold", mac.r_data, exp);
      check("s_ready_hold", mac.s_ready, 0);
      check("r_valid_hold", mac.r_valid, 1);
      @(negedge clk);
    end
    check("r_data", mac.r_data, exp);
    mac.r_ready = 1'b1;
    @(negedge clk);
    mac.r_ready = 1'b0;
    check("r_valid_after_hs", mac.r_valid, 0);
    check("s_ready_after_hs", mac.s_ready, 1);
  endtask

  task automatic flush_from(input int first_cancelled);
    int      tc[$];
    op_exp_t to[$];
    foreach (cep_q[i]) if (cep_q[i] < first_cancelled) tc.push_back(cep_q[i]);
    foreach (op_q[i]) if (op_q[i].at < first_cancelled) to.push_back(op_q[i]);
    cep_q    = tc;
    op_q     = to;
    beat_idx = 0;
    exp_sum  = '0;
  endtask

  initial begin
    mac.s_valid = 1'b0;
    mac.s_a     = '0;
    mac.s_b     = '0;
    mac.r_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", mac.s_ready, 0);
    check("rst_r_valid", mac.r_valid, 0);
    check("rst_r_data", mac.r_data, 0);
    check("rst_dsp_a", mac.dsp_a, 0);
    check("rst_opmode", mac.dsp_opmode, 0);
    check("rst_cep", mac.dsp_cep, 0);
    check("rst_rstp", mac.dsp_rstp, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", mac.s_ready, 1);

    for (int i = 1; i <= 4; i++) send(18'(i), 18'd2);
    get_result(0);

    send(18'd1, 18'd2);
    send(18'd2, 18'd2);
    repeat (2) @(negedge clk);
    send(18'd3, 18'd2);
    send(18'd4, 18'd2);
    get_result(0);

    repeat (4) send(18'h3FFFF, 18'h3FFFF);
    get_result(0);

    for (int i = 5; i <= 8; i++) send(18'(i), 18'd3);
    get_result(10);

    send(18'd7, 18'd9);
    send(18'd7, 18'd9);
    abort = 1'b1;
    flush_from(cyc + 1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_rstp", mac.dsp_rstp, 1);
    check("abort_cep", mac.dsp_cep, 0);
    check("abort_opmode", mac.dsp_opmode, 0);
    @(negedge clk);
    check("abort_rstp_clear", mac.dsp_rstp, 0);
    check("abort_no_rvalid", mac.r_valid, 0);
    repeat (4) send(18'd1, 18'd1);
    get_result(0);

    repeat (4) send(18'd3, 18'd3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    cep_q.delete();
    op_q.delete();
    rise_q.delete();
    res_q.delete();
    beat_idx = 0;
    exp_sum  = '0;
    #1;
    check("midrst_r_valid", mac.r_valid, 0);
    check("midrst_s_ready", mac.s_ready, 0);
    check("midrst_cep", mac.dsp_cep, 0);
    check("midrst_opmode", mac.dsp_opmode, 0);
    check("midrst_dsp_a", mac.dsp_a, 0);
    check("midrst_r_data", mac.r_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) send(18'(i), 18'd5);
    get_result(0);

    repeat (3) @(negedge clk);
    check("cep_left", cep_q.size(), 0);
    check("opmode_left", op_q.size(), 0);
    check("rise_left", rise_q.size(), 0);
    check("result_left", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
